// File: rtl/tx_control_if.sv
// Host-side bundle of the UART transmit controller: frame config, data, strobe and line outputs.
// The master drives the configuration and strobe; the slave drives the serial line and ready flag.
interface tx_control_if;
    logic        enable_in;
    logic        n_wr_in;
    logic        s_num_in;
    logic [31:0] clk_div_baud_in;
    logic [1:0]  parity_in;
    logic        d_num_in;
    logic [7:0]  data_in;
    logic        tx_out;
    logic        tx_rdy_out;

    modport master (
        output enable_in, n_wr_in, s_num_in, clk_div_baud_in, parity_in, d_num_in, data_in,
        input  tx_out, tx_rdy_out
    );

    modport slave (
        input  enable_in, n_wr_in, s_num_in, clk_div_baud_in, parity_in, d_num_in, data_in,
        output tx_out, tx_rdy_out
    );
endinterface

// File: rtl/tx_control.sv
// UART transmitter: one frame per rising write strobe; tx_out falls one clock after the sampled strobe.
// No queuing: strobes while tx_rdy_out is low are dropped; config is latched at frame start.
module tx_control (
    input  logic         clk_in,
    input  logic         reset_in,
    tx_control_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] div_q, div_d;
    logic [7:0]  data_q, data_d;
    logic        d7_q, d7_d;
    logic [1:0]  par_q, par_d;
    logic        s2_q, s2_d;
    logic [2:0]  bit_q, bit_d;
    logic        stop_q, stop_d;
    logic        tx_q, tx_d;
    logic        rdy_q, rdy_d;
    logic        wr_prev_q;

    logic        accept;
    logic        bit_end;
    logic        last_data;
    logic        par_en;
    logic        data_xor;
    logic        par_bit;
    logic [2:0]  bit_nxt;

    assign accept    = bus.n_wr_in && !wr_prev_q && bus.enable_in && (state_q == IDLE);
    assign bit_end   = (cnt_q == div_q - 32'd1);
    assign last_data = (bit_q == (d7_q ? 3'd6 : 3'd7));
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    // In 7-bit mode bit 7 of the latched byte is never sent, so it must not feed parity.
    assign data_xor  = ^(data_q & {~d7_q, 7'h7F});
    assign par_bit   = (par_q == 2'b01) ? ~data_xor : data_xor;
    assign bit_nxt   = bit_q + 3'd1;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            div_q     <= 32'd1;
            data_q    <= 8'd0;
            d7_q      <= 1'b0;
            par_q     <= 2'b00;
            s2_q      <= 1'b0;
            bit_q     <= 3'd0;
            stop_q    <= 1'b0;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b1;
            wr_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            data_q    <= data_d;
            d7_q      <= d7_d;
            par_q     <= par_d;
            s2_q      <= s2_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            tx_q      <= tx_d;
            rdy_q     <= rdy_d;
            wr_prev_q <= bus.n_wr_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        data_d  = data_q;
        d7_d    = d7_q;
        par_d   = par_q;
        s2_d    = s2_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        rdy_d   = rdy_q;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? 32'd0 : cnt_q + 32'd1;
        end

        // tx_d carries the level of the state being entered, keeping tx_out a pure register.
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    cnt_d   = 32'd0;
                    div_d   = (bus.clk_div_baud_in == 32'd0) ? 32'd1 : bus.clk_div_baud_in;
                    data_d  = bus.data_in;
                    d7_d    = bus.d_num_in;
                    par_d   = bus.parity_in;
                    s2_d    = bus.s_num_in;
                    tx_d    = 1'b0;
                    rdy_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (!last_data) begin
                        bit_d = bit_nxt;
                        tx_d  = data_q[bit_nxt];
                    end else if (par_en) begin
                        state_d = PARITY;
                        tx_d    = par_bit;
                    end else begin
                        state_d = STOP;
                        stop_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == s2_q) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                rdy_d   = 1'b1;
            end
        endcase
    end

    assign bus.tx_out     = tx_q;
    assign bus.tx_rdy_out = rdy_q;
endmodule

// File: tb/tb_tx_control.sv
// Directed bench for tx_control: frames are checked bit-by-bit against a locally built frame model.
module tb_tx_control;
    logic clk_in   = 1'b0;
    logic reset_in = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    tx_control_if bus ();

    tx_control dut (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    always #10 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe one frame and check every cycle of it. With poke set, a second strobe, changed
    // inputs and a dropped enable are applied mid-frame, and a strobe edge lands on the final edge.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic d7,
                              input logic [1:0] par, input logic s2, input logic [31:0] divc,
                              input bit poke);
        logic bits [0:12];
        int   nb, n, div;
        logic p, bit_ok, rdy_ok;
        div = (divc == 0) ? 1 : int'(divc);
        n   = d7 ? 7 : 8;
        nb  = 0;
        bits[nb] = 1'b0; nb++;
        p = 1'b0;
        for (int i = 0; i < n; i++) begin
            bits[nb] = d[i]; nb++;
            p = p ^ d[i];
        end
        if (par == 2'b01) begin bits[nb] = ~p; nb++; end
        if (par == 2'b10) begin bits[nb] = p;  nb++; end
        bits[nb] = 1'b1; nb++;
        if (s2) begin bits[nb] = 1'b1; nb++; end

        @(negedge clk_in);
        bus.data_in = d; bus.d_num_in = d7; bus.parity_in = par; bus.s_num_in = s2;
        bus.clk_div_baud_in = divc; bus.enable_in = 1'b1; bus.n_wr_in = 1'b1;
        @(posedge clk_in);
        rdy_ok = 1'b1;
        for (int b = 0; b < nb; b++) begin
            bit_ok = 1'b1;
            for (int c = 0; c < div; c++) begin
                @(negedge clk_in);
                if (bus.tx_out !== bits[b]) bit_ok = 1'b0;
                if (bus.tx_rdy_out !== 1'b0) rdy_ok = 1'b0;
                if (poke) begin
                    if (b == 3 && c == 0) begin
                        bus.n_wr_in = 1'b0; bus.data_in = ~d; bus.parity_in = ~par;
                        bus.s_num_in = ~s2; bus.d_num_in = ~d7; bus.clk_div_baud_in = divc + 3;
                    end
                    if (b == 3 && c == 1) bus.n_wr_in = 1'b1;
                    if (b == 5 && c == 0) bus.enable_in = 1'b0;
                    if (b == nb - 1 && c == div - 2) begin
                        bus.n_wr_in = 1'b0; bus.enable_in = 1'b1;
                    end
                    if (b == nb - 1 && c == div - 1) bus.n_wr_in = 1'b1;
                end
            end
            chk($sformatf("%s_bit%0d", tag, b), {31'd0, bit_ok}, 32'd1);
        end
        chk({tag, "_rdy_low_whole_frame"}, {31'd0, rdy_ok}, 32'd1);
        @(negedge clk_in);
        chk({tag, "_end_rdy"}, {31'd0, bus.tx_rdy_out}, 32'd1);
        chk({tag, "_end_tx"},  {31'd0, bus.tx_out}, 32'd1);
        bus.n_wr_in = 1'b0; bus.enable_in = 1'b1;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_in);
            if (bus.tx_out !== 1'b1 || bus.tx_rdy_out !== 1'b1) ok = 1'b0;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        bus.enable_in = 1'b1; bus.n_wr_in = 1'b1; bus.s_num_in = 1'b0;
        bus.clk_div_baud_in = 32'd5208; bus.parity_in = 2'b00; bus.d_num_in = 1'b0;
        bus.data_in = 8'h75;

        repeat (2) @(negedge clk_in);
        chk("reset_tx",  {31'd0, bus.tx_out}, 32'd1);
        chk("reset_rdy", {31'd0, bus.tx_rdy_out}, 32'd1);
        reset_in = 1'b0;
        idle_check("strobe_held_high_from_reset", 4);
        bus.n_wr_in = 1'b0;
        @(negedge clk_in);

        send_frame("f8n1_5208", 8'h75, 1'b0, 2'b00, 1'b0, 32'd5208, 1'b0);
        send_frame("f8n1_repeat", 8'h75, 1'b0, 2'b00, 1'b0, 32'd16, 1'b0);
        send_frame("f7e2", 8'h41, 1'b1, 2'b10, 1'b1, 32'd4, 1'b1);
        idle_check("no_extra_frame_after_pokes", 12);
        send_frame("f8o1_ff", 8'hFF, 1'b0, 2'b01, 1'b0, 32'd4, 1'b0);
        send_frame("f8o1_00", 8'h00, 1'b0, 2'b01, 1'b0, 32'd4, 1'b0);
        send_frame("f8o1_01", 8'h01, 1'b0, 2'b01, 1'b0, 32'd4, 1'b0);
        send_frame("div0", 8'h5A, 1'b0, 2'b11, 1'b0, 32'd0, 1'b0);

        @(negedge clk_in);
        bus.enable_in = 1'b0; bus.n_wr_in = 1'b1;
        idle_check("enable_low_strobe_ignored", 20);
        bus.n_wr_in = 1'b0; bus.enable_in = 1'b1;
        @(negedge clk_in);

        bus.data_in = 8'hA5; bus.d_num_in = 1'b0; bus.parity_in = 2'b00;
        bus.s_num_in = 1'b0; bus.clk_div_baud_in = 32'd4; bus.n_wr_in = 1'b1;
        @(posedge clk_in);
        repeat (10) @(negedge clk_in);
        chk("pre_reset_data_bit1", {31'd0, bus.tx_out}, 32'd0);
        reset_in = 1'b1;
        #1;
        chk("async_reset_tx",  {31'd0, bus.tx_out}, 32'd1);
        chk("async_reset_rdy", {31'd0, bus.tx_rdy_out}, 32'd1);
        @(negedge clk_in);
        reset_in = 1'b0;
        idle_check("post_reset_idle", 3);
        bus.n_wr_in = 1'b0;
        @(negedge clk_in);
        send_frame("after_reset", 8'hA5, 1'b0, 2'b00, 1'b0, 32'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
